// File: rtl/regfile_bypass_sb.sv
// Parametrised integer register file with same-cycle write-to-read bypass and a
// per-register pending scoreboard used by decode to detect RAW hazards.
module regfile_bypass_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NRD*$clog2(NREG)-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]             rd_data,
    output logic [NRD-1:0]                  rd_busy,
    input  logic                            wr_en,
    input  logic [$clog2(NREG)-1:0]         wr_addr,
    input  logic [XLEN-1:0]                 wr_data,
    input  logic                            alloc_en,
    input  logic [$clog2(NREG)-1:0]         alloc_addr,
    input  logic                            flush,
    output logic [$clog2(NREG):0]           pend_cnt
);

    localparam int AW = $clog2(NREG);
    localparam bit ZR = (ZERO_REG != 0);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [AW:0]     pend_cnt_q;
    logic [AW:0]     pend_cnt_d;
    logic            wr_eff_s;
    logic            alloc_eff_s;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] vec);
        logic [AW:0] cnt;
        cnt = {(AW+1){1'b0}};
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {{AW{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Qualify write/alloc: a hardwired zero register never takes data or pending state.
    always_comb begin
        wr_eff_s    = wr_en && !(ZR && (wr_addr == {AW{1'b0}}));
        alloc_eff_s = alloc_en && !(ZR && (alloc_addr == {AW{1'b0}}));
    end

    // Next-state register array.
    always_comb begin
        regs_d = regs_q;
        if (wr_eff_s) begin
            regs_d[wr_addr] = wr_data;
        end else begin
            regs_d[wr_addr] = regs_q[wr_addr];
        end
    end

    // Next-state pending vector: flush beats alloc beats writeback clear.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = {NREG{1'b0}};
        end else begin
            if (wr_eff_s) begin
                pend_d[wr_addr] = 1'b0;
            end else begin
                pend_d[wr_addr] = pend_q[wr_addr];
            end
            if (alloc_eff_s) begin
                pend_d[alloc_addr] = 1'b1;
            end else begin
                pend_d[alloc_addr] = pend_d[alloc_addr];
            end
        end
        pend_cnt_d = popcount(pend_d);
    end

    // State registers, cleared immediately by async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            pend_q     <= {NREG{1'b0}};
            pend_cnt_q <= {(AW+1){1'b0}};
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    // Combinational read ports; bypass is suppressed while in reset since no write lands.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        rd_busy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            if (ZR && (rd_addr[i*AW +: AW] == {AW{1'b0}})) begin
                rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy[i]              = 1'b0;
            end else if (rst_n && wr_en && (wr_addr == rd_addr[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = wr_data;
                rd_busy[i]              = 1'b0;
            end else begin
                rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
                rd_busy[i]              = pend_q[rd_addr[i*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: default configuration (instance a) and
// a 16x64, 3-port, ordinary-x0 configuration (instance b).
module tb_regfile_bypass_sb;

    logic clk;
    int   n_total;
    int   n_bad;

    // Instance a: XLEN=32, NREG=32, NRD=2, ZERO_REG=1
    logic        a_rst_n;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_alloc_en;
    logic [4:0]  a_alloc_addr;
    logic        a_flush;
    logic [5:0]  a_pend_cnt;

    // Instance b: XLEN=64, NREG=16, NRD=3, ZERO_REG=0
    logic         b_rst_n;
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic         b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_alloc_en;
    logic [3:0]   b_alloc_addr;
    logic         b_flush;
    logic [4:0]   b_pend_cnt;

    regfile_bypass_sb #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .flush(a_flush),
        .pend_cnt(a_pend_cnt)
    );

    regfile_bypass_sb #(.XLEN(64), .NREG(16), .NRD(3), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(b_rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr), .flush(b_flush),
        .pend_cnt(b_pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_wr_en = 1'b0; a_wr_addr = 5'd0; a_wr_data = 32'd0;
        a_alloc_en = 1'b0; a_alloc_addr = 5'd0; a_flush = 1'b0;
    endtask

    task automatic b_idle();
        b_wr_en = 1'b0; b_wr_addr = 4'd0; b_wr_data = 64'd0;
        b_alloc_en = 1'b0; b_alloc_addr = 4'd0; b_flush = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        a_idle();
        b_idle();
        a_rd_addr = {5'd3, 5'd3};
        b_rd_addr = {4'd3, 4'd3, 4'd3};
        #3;
        chk("rst_data", a_rd_data, 64'd0);
        chk("rst_busy", {62'd0, a_rd_busy}, 64'd0);
        chk("rst_cnt", {58'd0, a_pend_cnt}, 64'd0);
        step();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        step();
        chk("rst_rel_data", a_rd_data, 64'd0);

        // Write to x0 is discarded with the zero register
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hDEADBEEF;
        a_rd_addr = {5'd3, 5'd0};
        #1;
        chk("x0_bypass", {32'd0, a_rd_data[31:0]}, 64'd0);
        step();
        a_idle();
        #1;
        chk("x0_after", {32'd0, a_rd_data[31:0]}, 64'd0);

        // Same-cycle bypass, then array read
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'h12345678;
        a_rd_addr = {5'd3, 5'd5};
        #1;
        chk("byp_data", {32'd0, a_rd_data[31:0]}, 64'h12345678);
        step();
        a_idle();
        #1;
        chk("arr_data", {32'd0, a_rd_data[31:0]}, 64'h12345678);

        // Alloc x7, visible next cycle; write at N+3 clears busy same cycle
        a_alloc_en = 1'b1; a_alloc_addr = 5'd7;
        a_rd_addr = {5'd7, 5'd5};
        #1;
        chk("alloc_nolook", {63'd0, a_rd_busy[1]}, 64'd0);
        step();
        a_idle();
        #1;
        chk("alloc_busy", {63'd0, a_rd_busy[1]}, 64'd1);
        chk("alloc_cnt", {58'd0, a_pend_cnt}, 64'd1);
        step();
        step();
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h000000A5;
        #1;
        chk("wb_busy", {63'd0, a_rd_busy[1]}, 64'd0);
        chk("wb_data", {32'd0, a_rd_data[63:32]}, 64'hA5);
        step();
        a_idle();
        #1;
        chk("wb_cnt", {58'd0, a_pend_cnt}, 64'd0);
        chk("wb_busy_after", {63'd0, a_rd_busy[1]}, 64'd0);

        // Alloc and write of x9 in the same cycle: alloc wins the pending bit
        a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h55;
        a_rd_addr = {5'd3, 5'd9};
        #1;
        chk("aw_byp", {32'd0, a_rd_data[31:0]}, 64'h55);
        step();
        a_idle();
        #1;
        chk("aw_data", {32'd0, a_rd_data[31:0]}, 64'h55);
        chk("aw_busy", {63'd0, a_rd_busy[0]}, 64'd1);
        chk("aw_cnt", {58'd0, a_pend_cnt}, 64'd1);

        // Alloc of x0 never marks pending
        a_alloc_en = 1'b1; a_alloc_addr = 5'd0;
        step();
        a_idle();
        #1;
        chk("alloc_x0_cnt", {58'd0, a_pend_cnt}, 64'd1);

        // Three allocs then flush with concurrent alloc and write
        for (int r = 1; r <= 3; r++) begin
            a_alloc_en = 1'b1; a_alloc_addr = r[4:0];
            step();
        end
        a_idle();
        #1;
        chk("multi_cnt", {58'd0, a_pend_cnt}, 64'd4);
        a_flush = 1'b1;
        a_alloc_en = 1'b1; a_alloc_addr = 5'd4;
        a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'h99;
        step();
        a_idle();
        a_rd_addr = {5'd4, 5'd10};
        #1;
        chk("flush_cnt", {58'd0, a_pend_cnt}, 64'd0);
        chk("flush_data", {32'd0, a_rd_data[31:0]}, 64'h99);
        chk("flush_x4", {63'd0, a_rd_busy[1]}, 64'd0);
        a_rd_addr = {5'd9, 5'd2};
        #1;
        chk("flush_x9x2", {62'd0, a_rd_busy}, 64'd0);

        // Double alloc counts once; then re-pend x6 holding data 0x77
        a_alloc_en = 1'b1; a_alloc_addr = 5'd6;
        step();
        step();
        a_idle();
        #1;
        chk("dbl_alloc_cnt", {58'd0, a_pend_cnt}, 64'd1);
        a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'h77;
        step();
        a_idle();
        a_alloc_en = 1'b1; a_alloc_addr = 5'd6;
        step();
        a_idle();
        a_rd_addr = {5'd6, 5'd6};
        #1;
        chk("x6_data", a_rd_data, {32'h77, 32'h77});
        chk("x6_busy", {62'd0, a_rd_busy}, 64'd3);
        chk("x6_cnt", {58'd0, a_pend_cnt}, 64'd1);

        // Mid-cycle reset with write and alloc active
        a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'h1111;
        a_alloc_en = 1'b1; a_alloc_addr = 5'd6;
        #1;
        a_rst_n = 1'b0;
        #1;
        chk("midrst_data", a_rd_data, 64'd0);
        chk("midrst_busy", {62'd0, a_rd_busy}, 64'd0);
        chk("midrst_cnt", {58'd0, a_pend_cnt}, 64'd0);
        step();
        a_idle();
        a_rst_n = 1'b1;
        a_rd_addr = {5'd10, 5'd5};
        #1;
        chk("midrst_x10", a_rd_data, 64'd0);

        // Instance b: x0 is an ordinary register
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'hCAFEBABE01234567;
        b_rd_addr = {4'd0, 4'd3, 4'd3};
        #1;
        chk("b_x0_byp", b_rd_data[191:128], 64'hCAFEBABE01234567);
        step();
        b_idle();
        b_rd_addr = {4'd0, 4'd0, 4'd0};
        #1;
        chk("b_x0_p0", b_rd_data[63:0], 64'hCAFEBABE01234567);
        chk("b_x0_p1", b_rd_data[127:64], 64'hCAFEBABE01234567);
        chk("b_x0_p2", b_rd_data[191:128], 64'hCAFEBABE01234567);
        b_alloc_en = 1'b1; b_alloc_addr = 4'd0;
        step();
        b_alloc_addr = 4'd15;
        step();
        b_idle();
        #1;
        chk("b_x0_busy", {61'd0, b_rd_busy}, 64'd7);
        chk("b_cnt2", {59'd0, b_pend_cnt}, 64'd2);
        b_flush = 1'b1;
        b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'h0123456789ABCDEF;
        step();
        b_idle();
        b_rd_addr = {4'd15, 4'd15, 4'd0};
        #1;
        chk("b_flush_cnt", {59'd0, b_pend_cnt}, 64'd0);
        chk("b_x15", b_rd_data[191:128], 64'h0123456789ABCDEF);
        chk("b_busy", {61'd0, b_rd_busy}, 64'd0);

        // Instance b mid-cycle reset
        b_alloc_en = 1'b1; b_alloc_addr = 4'd3;
        step();
        b_idle();
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'h5A5A;
        b_rd_addr = {4'd3, 4'd15, 4'd0};
        #1;
        chk("b_pre_rst_cnt", {59'd0, b_pend_cnt}, 64'd1);
        b_rst_n = 1'b0;
        #1;
        chk("b_rst_data", b_rd_data, 192'd0);
        chk("b_rst_busy", {61'd0, b_rd_busy}, 64'd0);
        chk("b_rst_cnt", {59'd0, b_pend_cnt}, 64'd0);
        step();
        b_idle();
        b_rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
